// File: rtl/hps_cmd_pkg.sv
// Shared constants and types for the HPS command decoder.
// Holds the command codes, the status register geometry and the framing FSM states.
package hps_cmd_pkg;
   localparam int STATUS_W     = 128;
   localparam int STATUS_WORDS = STATUS_W / 16;

   localparam logic [15:0] CMD_BUTTONS    = 16'h0001;
   localparam logic [15:0] CMD_STATUS_SET = 16'h001E;
   localparam logic [15:0] CMD_STATUS_GET = 16'h0029;
   localparam logic [15:0] CMD_CORE_ID    = 16'h002B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;
endpackage

// File: rtl/hps_cmd_decoder_if.sv
// Word-level channel between the HPS SPI interface and the command decoder.
// The master side supplies the framed word stream; the slave side presents decoded results.
interface hps_cmd_decoder_if;
   import hps_cmd_pkg::*;

   logic                io_enable;
   logic                io_strobe;
   logic [15:0]         io_din;
   logic [15:0]         io_dout;
   logic [15:0]         io_cmd;
   logic                io_cmd_valid;
   logic [7:0]          io_word_cnt;
   logic [15:0]         io_data;
   logic                io_data_strobe;
   logic [STATUS_W-1:0] status;
   logic                status_set;
   logic [15:0]         buttons;

   modport master (
      output io_enable, io_strobe, io_din,
      input  io_dout, io_cmd, io_cmd_valid, io_word_cnt, io_data, io_data_strobe,
      input  status, status_set, buttons
   );

   modport slave (
      input  io_enable, io_strobe, io_din,
      output io_dout, io_cmd, io_cmd_valid, io_word_cnt, io_data, io_data_strobe,
      output status, status_set, buttons
   );
endinterface

// File: rtl/hps_status_reg.sv
// Core status register with a write shadow and a word read-back mux.
// Words 0..6 collect in the shadow; word 7 commits all 128 bits at once.
module hps_status_reg
   import hps_cmd_pkg::*;
(
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [7:0]          idx,
   input  logic [15:0]         word,
   input  logic                we,
   input  logic                abort,
   input  logic [8:0]          rd_idx,
   output logic [15:0]         rd_word,
   output logic [STATUS_W-1:0] status,
   output logic                status_set
);

   logic [STATUS_W-17:0] shadow;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         shadow     <= '0;
         status     <= '0;
         status_set <= 1'b0;
      end else begin
         status_set <= 1'b0;
         if (abort) begin
            shadow <= '0;
         end else if (we && idx < 8'd7) begin
            shadow[{idx[2:0], 4'b0000} +: 16] <= word;
         end else if (we && idx == 8'd7) begin
            status     <= {word, shadow};
            status_set <= 1'b1;
         end
      end
   end

   always_comb begin
      rd_word = '0;
      if (rd_idx < 9'(STATUS_WORDS))
         rd_word = status[{rd_idx[2:0], 4'b0000} +: 16];
   end

endmodule

// File: rtl/hps_cmd_decoder.sv
// Frames HPS words into command + data, decodes the core command set and
// preloads the response word for the next SPI transfer.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | io_enable low, no frame open
//   ST_CMD  | frame open, waiting for the command word
//   ST_DATA | command latched, consuming data words
module hps_cmd_decoder
   import hps_cmd_pkg::*;
#(
   parameter logic [15:0] CORE_ID = 16'h0000
) (
   input logic               clk_sys,
   input logic               reset,
   hps_cmd_decoder_if.slave  bus
);

   state_t              state_q, state_d;
   logic                cmd_stb, data_stb;
   logic [15:0]         cmd_q, data_q, dout_q, buttons_q;
   logic                cmd_valid_q, data_stb_q;
   logic [7:0]          word_cnt_q, next_k_q;
   logic [15:0]         resp_cmd, resp_word, rd_word;
   logic [8:0]          resp_idx;
   logic                shadow_we, frame_abort;
   logic [STATUS_W-1:0] status_w;
   logic                status_set_w;

   always_ff @(posedge clk_sys) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Dropping io_enable wins over a coincident strobe, so the strobe is only seen with enable high.
   always_comb begin
      state_d  = state_q;
      cmd_stb  = 1'b0;
      data_stb = 1'b0;
      if (!bus.io_enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_CMD;
            ST_CMD: if (bus.io_strobe) begin
               cmd_stb = 1'b1;
               state_d = ST_DATA;
            end
            ST_DATA: if (bus.io_strobe) data_stb = 1'b1;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      resp_cmd  = cmd_stb ? bus.io_din : cmd_q;
      resp_idx  = cmd_stb ? 9'd0 : ({1'b0, next_k_q} + 9'd1);
      resp_word = '0;
      case (resp_cmd)
         CMD_STATUS_GET: resp_word = rd_word;
         CMD_CORE_ID:    resp_word = (resp_idx == 9'd0) ? CORE_ID : 16'h0000;
         default:        resp_word = '0;
      endcase
   end

   assign shadow_we   = data_stb && (cmd_q == CMD_STATUS_SET);
   assign frame_abort = !bus.io_enable;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         word_cnt_q  <= '0;
         next_k_q    <= '0;
         data_q      <= '0;
         data_stb_q  <= 1'b0;
         dout_q      <= '0;
         buttons_q   <= '0;
      end else begin
         data_stb_q <= 1'b0;
         if (!bus.io_enable) begin
            cmd_valid_q <= 1'b0;
            dout_q      <= '0;
         end
         if (cmd_stb) begin
            cmd_q       <= bus.io_din;
            cmd_valid_q <= 1'b1;
            word_cnt_q  <= '0;
            next_k_q    <= '0;
            dout_q      <= resp_word;
         end
         if (data_stb) begin
            data_q     <= bus.io_din;
            data_stb_q <= 1'b1;
            word_cnt_q <= next_k_q;
            next_k_q   <= (next_k_q == 8'hFF) ? 8'hFF : next_k_q + 8'd1;
            dout_q     <= resp_word;
            if (cmd_q == CMD_BUTTONS && next_k_q == 8'd0)
               buttons_q <= bus.io_din;
         end
      end
   end

   hps_status_reg u_status (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .idx        (next_k_q),
      .word       (bus.io_din),
      .we         (shadow_we),
      .abort      (frame_abort),
      .rd_idx     (resp_idx),
      .rd_word    (rd_word),
      .status     (status_w),
      .status_set (status_set_w)
   );

   assign bus.io_dout        = dout_q;
   assign bus.io_cmd         = cmd_q;
   assign bus.io_cmd_valid   = cmd_valid_q;
   assign bus.io_word_cnt    = word_cnt_q;
   assign bus.io_data        = data_q;
   assign bus.io_data_strobe = data_stb_q;
   assign bus.status         = status_w;
   assign bus.status_set     = status_set_w;
   assign bus.buttons        = buttons_q;

endmodule

// File: tb/tb_hps_cmd_decoder.sv
// Directed bench for hps_cmd_decoder: a vector table for status write/read-back
// plus hand-written framing, abort, saturation and reset sequences.
module tb_hps_cmd_decoder;
   import hps_cmd_pkg::*;

   typedef struct {
      logic        en;
      logic        stb;
      logic [15:0] din;
      logic [15:0] dout;
      logic [7:0]  cnt;
      logic        dstb;
      logic        sset;
      logic        valid;
   } vec_t;

   logic   clk_sys;
   logic   reset;
   int     n_checks;
   int     n_fail;
   int     sset_seen;
   int     sset0;
   int     nz;
   vec_t   vecs[$];

   hps_cmd_decoder_if bus ();

   hps_cmd_decoder #(.CORE_ID(16'hBEEF)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic en, input logic stb, input logic [15:0] din);
      bus.io_enable = en;
      bus.io_strobe = stb;
      bus.io_din    = din;
      @(posedge clk_sys);
      #1;
      sset_seen += int'(bus.status_set);
   endtask

   task automatic add(input logic en, input logic stb, input logic [15:0] din, input logic [15:0] dout,
                      input logic [7:0] cnt, input logic dstb, input logic sset, input logic valid);
      vec_t v;
      v.en = en; v.stb = stb; v.din = din; v.dout = dout;
      v.cnt = cnt; v.dstb = dstb; v.sset = sset; v.valid = valid;
      vecs.push_back(v);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      sset_seen = 0;
      bus.io_enable = 1'b0;
      bus.io_strobe = 1'b0;
      bus.io_din    = '0;
      reset = 1'b1;
      step(0, 0, 16'h0);
      step(0, 0, 16'h0);

      check("rst_dout",    bus.io_dout, 0);
      check("rst_cmd",     bus.io_cmd, 0);
      check("rst_valid",   bus.io_cmd_valid, 0);
      check("rst_cnt",     bus.io_word_cnt, 0);
      check("rst_status",  bus.status, 0);
      check("rst_buttons", bus.buttons, 0);
      reset = 1'b0;

      // status write frame, then read-back frame
      add(1, 0, 16'h0000, 16'h0000, 8'd0, 0, 0, 0);
      add(1, 1, 16'h001E, 16'h0000, 8'd0, 0, 0, 1);
      for (int k = 0; k < 8; k++)
         add(1, 1, 16'(16'h1111 * (k + 1)), 16'h0000, 8'(k), 1, (k == 7), 1);
      add(0, 0, 16'h0000, 16'h0000, 8'd7, 0, 0, 0);
      add(1, 0, 16'h0000, 16'h0000, 8'd7, 0, 0, 0);
      add(1, 1, 16'h0029, 16'h1111, 8'd0, 0, 0, 1);
      for (int k = 0; k < 8; k++)
         add(1, 1, 16'h0000, (k < 7) ? 16'(16'h1111 * (k + 2)) : 16'h0000, 8'(k), 1, 0, 1);
      add(0, 0, 16'h0000, 16'h0000, 8'd7, 0, 0, 0);

      sset_seen = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].en, vecs[i].stb, vecs[i].din);
         check($sformatf("v%0d_dout", i),  bus.io_dout, vecs[i].dout);
         check($sformatf("v%0d_cnt", i),   bus.io_word_cnt, vecs[i].cnt);
         check($sformatf("v%0d_dstb", i),  bus.io_data_strobe, vecs[i].dstb);
         check($sformatf("v%0d_sset", i),  bus.status_set, vecs[i].sset);
         check($sformatf("v%0d_valid", i), bus.io_cmd_valid, vecs[i].valid);
      end
      check("tbl_status", bus.status, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
      check("tbl_sset_count", sset_seen, 1);

      // aborted status write leaves status alone; a following full write commits
      sset0 = sset_seen;
      step(1, 0, 16'h0);
      step(1, 1, 16'h001E);
      step(1, 1, 16'hAAAA);
      step(1, 1, 16'hBBBB);
      step(1, 1, 16'hCCCC);
      step(0, 0, 16'h0);
      check("abort_status", bus.status, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
      check("abort_no_sset", sset_seen, sset0);
      step(1, 0, 16'h0);
      step(1, 1, 16'h001E);
      for (int k = 0; k < 7; k++) step(1, 1, 16'(16'h0101 * (k + 1)));
      check("rewrite_pre_status", bus.status, 128'h8888_7777_6666_5555_4444_3333_2222_1111);
      step(1, 1, 16'h0808);
      check("rewrite_sset", bus.status_set, 1);
      check("rewrite_status", bus.status, 128'h0808_0707_0606_0505_0404_0303_0202_0101);
      step(0, 0, 16'h0);
      check("rewrite_sset_width", bus.status_set, 0);
      check("rewrite_sset_count", sset_seen, sset0 + 1);

      // buttons, then strobe coincident with enable falling
      step(1, 0, 16'h0);
      step(1, 1, 16'h0001);
      step(1, 1, 16'hA5A5);
      check("btn_buttons", bus.buttons, 16'hA5A5);
      check("btn_data", bus.io_data, 16'hA5A5);
      step(1, 1, 16'h1234);
      check("btn_second_ignored", bus.buttons, 16'hA5A5);
      check("btn_data2", bus.io_data, 16'h1234);
      check("btn_cnt", bus.io_word_cnt, 1);
      step(0, 1, 16'h5555);
      check("fall_data", bus.io_data, 16'h1234);
      check("fall_dstb", bus.io_data_strobe, 0);
      check("fall_cnt", bus.io_word_cnt, 1);
      check("fall_valid", bus.io_cmd_valid, 0);

      // one-cycle enable drop starts a new frame; core ID read-back
      step(1, 0, 16'h0);
      step(1, 1, 16'h0001);
      step(1, 1, 16'h0F0F);
      step(0, 0, 16'h0);
      step(1, 0, 16'h0);
      step(1, 1, 16'h002B);
      check("cid_cmd", bus.io_cmd, 16'h002B);
      check("cid_dout", bus.io_dout, 16'hBEEF);
      check("cid_buttons", bus.buttons, 16'h0F0F);
      step(1, 1, 16'h0000);
      check("cid_dout_w1", bus.io_dout, 16'h0000);
      step(0, 0, 16'h0);

      // unknown command, 300 back-to-back words
      step(1, 0, 16'h0);
      step(1, 1, 16'h00FF);
      check("unk_dout_cmd", bus.io_dout, 16'h0000);
      nz = 0;
      for (int i = 0; i < 300; i++) begin
         step(1, 1, 16'(i));
         if (bus.io_dout != 16'h0000) nz++;
         if (i == 254) check("sat_cnt_254", bus.io_word_cnt, 254);
      end
      check("unk_dout_zero", nz, 0);
      check("sat_cnt_255", bus.io_word_cnt, 255);
      check("unk_cmd", bus.io_cmd, 16'h00FF);
      check("unk_data", bus.io_data, 16'd299);
      step(0, 0, 16'h0);

      // reset during status write word 4
      step(1, 0, 16'h0);
      step(1, 1, 16'h001E);
      for (int k = 0; k < 4; k++) step(1, 1, 16'(16'h1000 + k));
      reset = 1'b1;
      step(1, 1, 16'h5555);
      check("mrst_dout",    bus.io_dout, 0);
      check("mrst_cmd",     bus.io_cmd, 0);
      check("mrst_valid",   bus.io_cmd_valid, 0);
      check("mrst_cnt",     bus.io_word_cnt, 0);
      check("mrst_data",    bus.io_data, 0);
      check("mrst_dstb",    bus.io_data_strobe, 0);
      check("mrst_status",  bus.status, 0);
      check("mrst_sset",    bus.status_set, 0);
      check("mrst_buttons", bus.buttons, 0);
      reset = 1'b0;
      step(1, 0, 16'h0);
      step(1, 1, 16'h0029);
      check("post_cmd", bus.io_cmd, 16'h0029);
      check("post_valid", bus.io_cmd_valid, 1);
      check("post_dout", bus.io_dout, 16'h0000);
      step(0, 0, 16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hps_cmd_decoder.md
# hps_cmd_decoder

Word-level command framer for the HPS I/O channel. Sits directly downstream of the HPS SPI interface: it consumes the 16-bit received word and its `io_strobe`, frames commands with `io_enable`, and decodes a small core command set (buttons, status write, status read-back, core ID). It also drives the 16-bit response word that the interface shifts back to the HPS on the next SPI word.

## Interface
- `CORE_ID`, 16'h0000, value returned by the core-ID read command.

Ports:
- `clk_sys`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `io_enable`  in  1  frame qualifier, already in the `clk_sys` domain; high for the whole command frame.
- `io_strobe`  in  1  one-cycle pulse: `io_din` holds a complete received word.
- `io_din`  in  16  received word.
- `io_dout`  out  16  response word for the next SPI word; feeds `gp_in[15:0]`.
- `io_cmd`  out  16  latched command word of the current or last frame.
- `io_cmd_valid`  out  1  high while a frame is open and its command has been latched.
- `io_word_cnt`  out  8  index of the last data word received in the frame; saturates at 255.
- `io_data`  out  16  last data word.
- `io_data_strobe`  out  1  one-cycle pulse per data word (not the command word).
- `status`  out  128  core status register.
- `status_set`  out  1  one-cycle pulse when `status` is updated.
- `buttons`  out  16  buttons/switches word.

## Operation
- FSM states:
  - IDLE: `io_enable` low.
  - CMD: frame open, waiting for the command word.
  - DATA: command latched.
- Transitions:
  - IDLE→CMD when `io_enable` is high.
  - CMD→DATA on `io_strobe`: latch `io_cmd<=io_din`, set `io_cmd_valid`, set the word counter to 0.
  - DATA stays in DATA on each `io_strobe`.
  - Any state→IDLE when `io_enable` is low. This has priority over a coincident `io_strobe`, which is then ignored.
- Data words: on each DATA-state strobe:
  - `io_data<=io_din`, pulse `io_data_strobe`.
  - `io_word_cnt` is the word's index k. The first data word is k=0.
  - The counter advances after each word and saturates at 255.
- Commands (constants in package):
  - `CMD_BUTTONS`=16'h0001: on word k=0, `buttons<=io_din`. Further words are ignored.
  - `CMD_STATUS_SET`=16'h001E: word k (0..7) goes to shadow bits [16k+15:16k]. On the k=7 strobe, `status<={io_din, shadow[111:0]}` and `status_set` pulses. Words k>7 are ignored. A frame that ends before k=7 leaves `status` unchanged and the shadow is discarded.
  - `CMD_STATUS_GET`=16'h0029: read-back of `status`, 8 words.
  - `CMD_CORE_ID`=16'h002B: read-back of `CORE_ID`.
  - Unknown commands: latched and counted, no side effects, response 0.
- Response generation:
  - On the command strobe, load `io_dout` with the response for data word 0.
  - On the data-word-k strobe, load `io_dout` with the response for word k+1.
  - STATUS_GET responses: word j = `status[16j+15:16j]` for j≤7, else 0.
  - CORE_ID responses: word 0 = `CORE_ID`, else 0.
  - In IDLE, `io_dout`=0.
- `io_cmd` and `io_word_cnt` retain their values after the frame closes. `io_cmd_valid` clears on entry to IDLE.

## Timing
- Reset values:
  - FSM=IDLE.
  - 0 for all outputs: `io_dout`, `io_cmd`, `io_cmd_valid`, `io_word_cnt`, `io_data`, `io_data_strobe`, `status`, `status_set`, `buttons`, and the shadow.
- Registered outputs all update on the `clk_sys` edge that samples `io_strobe` (1-cycle latency). This covers `io_cmd`, `io_data`, `io_data_strobe`, `io_dout`, `buttons`, `status` and `status_set`.
- `io_dout` is valid 1 cycle after the strobe. This is well before the next SPI word starts, given the ≥16 SPI clocks between strobes.
- `io_data_strobe` and `status_set` are exactly 1 cycle wide. They never assert in IDLE or for the command word.
- Back-to-back strobes on consecutive cycles must be handled; each is consumed.
- `io_enable` toggling low for 1 cycle closes the frame. The next word is then treated as a new command.
- `reset` mid-frame returns to IDLE with all outputs at reset values on the next edge.

## Structure
- Package `hps_cmd_pkg`: the `CMD_*` constants, a status width localparam (128), and the FSM state enum.
- Sub-module `hps_status_reg`: holds the shadow and `status`. Its inputs are the word index, word, write-enable and frame-abort. Its outputs are `status` and `status_set`. It also provides the read-back mux for STATUS_GET.
- The decoder top holds the FSM, counter and response register.

## Test plan
- Status write: frame with cmd 16'h001E and words 16'h1111..16'h8888 → `status`=128'h8888_7777_…_1111, one `status_set` pulse, 1 cycle after the 8th strobe.
- Aborted status write: cmd 16'h001E plus 3 words, then `io_enable` low → `status` unchanged, no `status_set`. A following full write still succeeds.
- Status read-back: after the write above, cmd 16'h0029 → `io_dout`=16'h1111 one cycle after the cmd strobe, then 16'h2222..16'h8888, then 0 after word 7.
- Buttons and core ID: cmd 16'h0001, data 16'hA5A5 → `buttons`=16'hA5A5. Cmd 16'h002B with `CORE_ID`=16'hBEEF → `io_dout`=16'hBEEF after the cmd strobe.
- Framing edges:
  - Strobe on the cycle `io_enable` falls → ignored.
  - Back-to-back strobes → both counted.
  - 300 data words → `io_word_cnt` saturates at 255.
  - Unknown cmd 16'h00FF → `io_dout` stays 0.
- Reset mid-frame during STATUS_SET word 4 → all outputs 0. The next frame is decoded from its command word.
